// File: rtl/jtkiwi_snd_pkg.sv
// Shared definitions for the Kiwi sound CPU control block:
// memory-map region codes and the region decoder used by the sound controller.
package jtkiwi_snd_pkg;

  localparam logic [3:0] REG_BANK  = 4'hA;
  localparam logic [3:0] REG_FM    = 4'hB;
  localparam logic [3:0] REG_CAB   = 4'hC;
  localparam logic [3:0] REG_RAM0  = 4'hD;
  localparam logic [3:0] REG_RAM1  = 4'hE;
  localparam logic [3:0] ROM_LIMIT = 4'hA;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_ROM,
    RG_BANK,
    RG_FM,
    RG_CAB,
    RG_RAM
  } region_e;

  function automatic region_e region_of(input logic [3:0] hi);
    region_e rg;
    rg = RG_NONE;
    if (hi < ROM_LIMIT) begin
      rg = RG_ROM;
    end else begin
      case (hi)
        REG_BANK: rg = RG_BANK;
        REG_FM:   rg = RG_FM;
        REG_CAB:  rg = RG_CAB;
        REG_RAM0,
        REG_RAM1: rg = RG_RAM;
        default:  rg = RG_NONE;
      endcase
    end
    return rg;
  endfunction

endpackage

// File: rtl/jtkiwi_sndctl_wdog.sv
// LVBL falling-edge detector and frame watchdog. The edge pulse also feeds
// the VBLANK interrupt; bank writes from the sound CPU keep the watchdog fed.
module jtkiwi_sndctl_wdog #(
  parameter int unsigned WDOG_EN     = 1,
  parameter int unsigned WDOG_FRAMES = 8
)(
  input  logic clk,
  input  logic comb_rstn,
  input  logic i_lvbl,
  input  logic i_bank_we,
  output logic o_vb_edge,
  output logic o_wdog_rst
);

  localparam logic [7:0] LAST_FRAME = 8'(WDOG_FRAMES - 1);

  logic       r_lvbl_last;
  logic [7:0] r_frames;
  logic       r_wdog;
  logic       w_edge;

  // r_lvbl_last resets low, so no edge is seen until LVBL has been sampled high
  assign w_edge = r_lvbl_last && !i_lvbl;

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      r_lvbl_last <= 1'b0;
      r_frames    <= '0;
      r_wdog      <= 1'b0;
    end else begin
      r_lvbl_last <= i_lvbl;
      r_wdog      <= 1'b0;
      if (i_bank_we) begin
        r_frames <= '0;
      end else if (w_edge) begin
        if (r_frames == LAST_FRAME) begin
          r_frames <= '0;
          r_wdog   <= (WDOG_EN != 0);
        end else begin
          r_frames <= r_frames + 8'd1;
        end
      end
    end
  end

  assign o_vb_edge  = w_edge;
  assign o_wdog_rst = r_wdog;

endmodule

// File: rtl/jtkiwi_sndctl.sv
// Sound Z80 control: registered address decode, ROM banking, read-data mux,
// VBLANK interrupt, FM wait stretching and frame watchdog.
module jtkiwi_sndctl #(
  parameter int unsigned BANKW       = 2,
  parameter int unsigned FMWAIT      = 1,
  parameter int unsigned WDOG_EN     = 1,
  parameter int unsigned WDOG_FRAMES = 8,
  parameter int unsigned IRQ_M1      = 0
)(
  input  logic               clk,
  input  logic               comb_rstn,
  input  logic               cen6,
  input  logic               LVBL,
  input  logic [15:0]        A,
  input  logic               mreq_n,
  input  logic               rfsh_n,
  input  logic               iorq_n,
  input  logic               m1_n,
  input  logic               wr_n,
  input  logic [7:0]         cpu_dout,
  input  logic [7:0]         rom_data,
  input  logic [7:0]         ram_dout,
  input  logic [7:0]         fm_dout,
  input  logic [7:0]         cab_dout,
  input  logic               mshramen,
  output logic [13+BANKW:0]  rom_addr,
  output logic               rom_cs,
  output logic               fm_cs,
  output logic               cab_cs,
  output logic               ram_cs,
  output logic [BANKW-1:0]   bank,
  output logic               mcu_rst,
  output logic [7:0]         din,
  output logic               int_n,
  output logic               dev_busy,
  output logic               wdog_rst
);
  import jtkiwi_snd_pkg::*;

  localparam int unsigned ROMW = 14 + BANKW;

  region_e          w_region;
  logic             w_mem_acc;
  logic             w_bank_we;
  logic             w_vb_edge;
  logic             w_irq_ack;
  logic             w_fm_busy;
  logic             w_unused;

  logic             r_rom_cs, r_fm_cs, r_cab_cs, r_ram_cs, r_bank_cs;
  logic [BANKW-1:0] r_bank;
  logic             r_mcu_rst;
  logic [7:0]       r_din;
  logic             r_irq;
  logic             r_fm_last;
  logic [3:0]       r_fm_cnt;

  assign w_mem_acc = !mreq_n && rfsh_n;
  assign w_region  = region_of(A[15:12]);
  // The bank region select is registered like the others; the write lands one clk later
  assign w_bank_we = r_bank_cs && !wr_n;
  assign w_unused  = &{1'b0, cpu_dout};

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      r_rom_cs  <= 1'b0;
      r_fm_cs   <= 1'b0;
      r_cab_cs  <= 1'b0;
      r_ram_cs  <= 1'b0;
      r_bank_cs <= 1'b0;
    end else begin
      r_rom_cs  <= w_mem_acc && (w_region == RG_ROM);
      r_fm_cs   <= w_mem_acc && (w_region == RG_FM);
      r_cab_cs  <= w_mem_acc && (w_region == RG_CAB);
      r_ram_cs  <= w_mem_acc && (w_region == RG_RAM);
      r_bank_cs <= w_mem_acc && (w_region == RG_BANK);
    end
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      r_bank    <= '0;
      r_mcu_rst <= 1'b0;
    end else if (w_bank_we) begin
      r_bank    <= cpu_dout[BANKW-1:0];
      r_mcu_rst <= cpu_dout[BANKW];
    end
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      r_din <= '0;
    end else begin
      if (r_rom_cs)      r_din <= rom_data;
      else if (r_ram_cs) r_din <= ram_dout;
      else if (r_fm_cs)  r_din <= fm_dout;
      else if (r_cab_cs) r_din <= cab_dout;
      else               r_din <= '0;
    end
  end

  assign w_irq_ack = (IRQ_M1 != 0) ? (!iorq_n && !m1_n) : !iorq_n;

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      r_irq <= 1'b0;
    end else if (w_vb_edge) begin
      r_irq <= 1'b1;
    end else if (w_irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      r_fm_last <= 1'b0;
      r_fm_cnt  <= '0;
    end else if (cen6) begin
      r_fm_last <= r_fm_cs;
      if (r_fm_cs && !r_fm_last) begin
        r_fm_cnt <= 4'(FMWAIT);
      end else if (r_fm_cnt != 4'd0) begin
        r_fm_cnt <= r_fm_cnt - 4'd1;
      end
    end
  end

  assign w_fm_busy = (r_fm_cnt != 4'd0);

  jtkiwi_sndctl_wdog #(
    .WDOG_EN     (WDOG_EN),
    .WDOG_FRAMES (WDOG_FRAMES)
  ) u_wdog (
    .clk        (clk),
    .comb_rstn  (comb_rstn),
    .i_lvbl     (LVBL),
    .i_bank_we  (w_bank_we),
    .o_vb_edge  (w_vb_edge),
    .o_wdog_rst (wdog_rst)
  );

  assign rom_addr = A[15] ? {1'b1, r_bank, A[12:0]} : ROMW'(A[14:0]);
  assign rom_cs   = r_rom_cs;
  assign fm_cs    = r_fm_cs;
  assign cab_cs   = r_cab_cs;
  assign ram_cs   = r_ram_cs;
  assign bank     = r_bank;
  assign mcu_rst  = r_mcu_rst;
  assign din      = r_din;
  assign int_n    = !r_irq;
  assign dev_busy = (mshramen && r_ram_cs) || w_fm_busy;

endmodule

// File: tb/tb_jtkiwi_sndctl.sv
// Self-checking bench for jtkiwi_sndctl (BANKW=2, FMWAIT=3, WDOG_FRAMES=4, IRQ_M1=1).
module tb_jtkiwi_sndctl;

  logic        clk = 1'b0;
  logic        comb_rstn, cen6, LVBL;
  logic [15:0] A;
  logic        mreq_n, rfsh_n, iorq_n, m1_n, wr_n;
  logic [7:0]  cpu_dout, rom_data, ram_dout, fm_dout, cab_dout;
  logic        mshramen;
  logic [15:0] rom_addr;
  logic        rom_cs, fm_cs, cab_cs, ram_cs;
  logic [1:0]  bank;
  logic        mcu_rst;
  logic [7:0]  din;
  logic        int_n, dev_busy, wdog_rst;

  int checks   = 0;
  int failures = 0;

  int exp_q[$];

  jtkiwi_sndctl #(
    .BANKW(2), .FMWAIT(3), .WDOG_EN(1), .WDOG_FRAMES(4), .IRQ_M1(1)
  ) dut (
    .clk(clk), .comb_rstn(comb_rstn), .cen6(cen6), .LVBL(LVBL), .A(A),
    .mreq_n(mreq_n), .rfsh_n(rfsh_n), .iorq_n(iorq_n), .m1_n(m1_n), .wr_n(wr_n),
    .cpu_dout(cpu_dout), .rom_data(rom_data), .ram_dout(ram_dout),
    .fm_dout(fm_dout), .cab_dout(cab_dout), .mshramen(mshramen),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .fm_cs(fm_cs), .cab_cs(cab_cs),
    .ram_cs(ram_cs), .bank(bank), .mcu_rst(mcu_rst), .din(din),
    .int_n(int_n), .dev_busy(dev_busy), .wdog_rst(wdog_rst)
  );

  always #5 clk = ~clk;

  // cen6 is one clk in four, changed on the falling edge
  initial begin
    int c = 0;
    cen6 = 1'b0;
    forever begin
      @(negedge clk);
      cen6 = (c == 3);
      c = (c + 1) % 4;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    @(posedge clk);
    while (!cen6 && n < 8) begin
      @(posedge clk);
      n++;
    end
    if (n >= 8) begin
      checks++; failures++;
      $display("FAIL cen6_wait got=no_tick exp=tick");
    end
    #1;
  endtask

  task automatic idle();
    mreq_n = 1'b1; rfsh_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; wr_n = 1'b1;
    A = 16'h0000; mshramen = 1'b0;
  endtask

  task automatic bank_write(input logic [7:0] val);
    A = 16'hA000; cpu_dout = val; mreq_n = 1'b0; wr_n = 1'b0;
    clk1(); clk1();
    wr_n = 1'b1; mreq_n = 1'b1;
    clk1();
  endtask

  function automatic logic [7:0] model_din(input logic [15:0] a, input logic mq, input logic rf);
    logic [3:0] hi;
    hi = a[15:12];
    if (mq || !rf)                     return 8'h00;
    if (hi < 4'hA)                     return rom_data;
    if (hi == 4'hD || hi == 4'hE)      return ram_dout;
    if (hi == 4'hB)                    return fm_dout;
    if (hi == 4'hC)                    return cab_dout;
    return 8'h00;
  endfunction

  task automatic test_reset();
    checks++; if (rom_cs !== 1'b0)  begin failures++; $display("FAIL rst_rom_cs got=%b exp=0", rom_cs); end
    checks++; if (fm_cs !== 1'b0)   begin failures++; $display("FAIL rst_fm_cs got=%b exp=0", fm_cs); end
    checks++; if (cab_cs !== 1'b0)  begin failures++; $display("FAIL rst_cab_cs got=%b exp=0", cab_cs); end
    checks++; if (ram_cs !== 1'b0)  begin failures++; $display("FAIL rst_ram_cs got=%b exp=0", ram_cs); end
    checks++; if (bank !== 2'd0)    begin failures++; $display("FAIL rst_bank got=%h exp=0", bank); end
    checks++; if (mcu_rst !== 1'b0) begin failures++; $display("FAIL rst_mcu_rst got=%b exp=0", mcu_rst); end
    checks++; if (din !== 8'h00)    begin failures++; $display("FAIL rst_din got=%h exp=00", din); end
    checks++; if (int_n !== 1'b1)   begin failures++; $display("FAIL rst_int_n got=%b exp=1", int_n); end
    checks++; if (dev_busy !== 1'b0) begin failures++; $display("FAIL rst_dev_busy got=%b exp=0", dev_busy); end
    checks++; if (wdog_rst !== 1'b0) begin failures++; $display("FAIL rst_wdog got=%b exp=0", wdog_rst); end
  endtask

  task automatic test_bank();
    bank_write(8'h05);
    checks++; if (bank !== 2'd1)    begin failures++; $display("FAIL bank_wr got=%h exp=1", bank); end
    checks++; if (mcu_rst !== 1'b1) begin failures++; $display("FAIL bank_mcu got=%b exp=1", mcu_rst); end
    A = 16'h8123; #1;
    checks++; if (rom_addr !== 16'hA123) begin failures++; $display("FAIL bank_rom_addr got=%h exp=A123", rom_addr); end
    A = 16'hA000; cpu_dout = 8'h02; mreq_n = 1'b0; wr_n = 1'b1;
    clk1(); clk1();
    checks++; if (bank !== 2'd1)    begin failures++; $display("FAIL bank_read got=%h exp=1", bank); end
    A = 16'h4321; #1;
    checks++; if (rom_addr !== 16'h4321) begin failures++; $display("FAIL lo_rom_addr got=%h exp=4321", rom_addr); end
    clk1();
    checks++; if (rom_cs !== 1'b1)  begin failures++; $display("FAIL rom_cs got=%b exp=1", rom_cs); end
    idle();
    clk1();
  endtask

  task automatic test_din_mux();
    logic [15:0] ta[10] = '{16'h1234, 16'hD010, 16'hB001, 16'hC002, 16'hE003,
                            16'hF000, 16'hA000, 16'h9FFF, 16'h0000, 16'h2000};
    logic        tm[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic        tr[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int got;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        A = ta[i]; mreq_n = tm[i]; rfsh_n = tr[i];
        exp_q.push_back(int'(model_din(ta[i], tm[i], tr[i])));
      end
      clk1();
      if (i >= 1) begin
        got = int'(din);
        checks++;
        if (got !== exp_q[0]) begin
          failures++;
          $display("FAIL din_mux[%0d] got=%h exp=%h", i - 1, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    idle();
    clk1();
  endtask

  task automatic test_fm_wait();
    for (int rep = 0; rep < 2; rep++) begin
      int busy_ticks = 0;
      idle();
      repeat (6) wait_tick();
      A = 16'hB000; mreq_n = 1'b0;
      for (int t = 0; t < 10; t++) begin
        wait_tick();
        if (dev_busy) busy_ticks++;
      end
      checks++; if (busy_ticks !== 3) begin failures++; $display("FAIL fm_busy_ticks[%0d] got=%0d exp=3", rep, busy_ticks); end
      checks++; if (dev_busy !== 1'b0) begin failures++; $display("FAIL fm_held_no_retrig got=%b exp=0", dev_busy); end
    end
    A = 16'hD000; mreq_n = 1'b0; mshramen = 1'b1;
    clk1();
    checks++; if (dev_busy !== 1'b1) begin failures++; $display("FAIL shram_busy got=%b exp=1", dev_busy); end
    mshramen = 1'b0; #1;
    checks++; if (dev_busy !== 1'b0) begin failures++; $display("FAIL shram_free got=%b exp=0", dev_busy); end
    idle();
    clk1();
  endtask

  task automatic test_irq();
    LVBL = 1'b1; clk1(); clk1();
    LVBL = 1'b0; clk1(); clk1();
    checks++; if (int_n !== 1'b0) begin failures++; $display("FAIL irq_set got=%b exp=0", int_n); end
    iorq_n = 1'b0; m1_n = 1'b1; clk1(); clk1();
    checks++; if (int_n !== 1'b0) begin failures++; $display("FAIL irq_no_m1 got=%b exp=0", int_n); end
    m1_n = 1'b0; clk1();
    checks++; if (int_n !== 1'b1) begin failures++; $display("FAIL irq_ack got=%b exp=1", int_n); end
    iorq_n = 1'b1; m1_n = 1'b1;
    LVBL = 1'b1; clk1(); clk1();
    LVBL = 1'b0; iorq_n = 1'b0; m1_n = 1'b0; clk1();
    iorq_n = 1'b1; m1_n = 1'b1;
    checks++; if (int_n !== 1'b0) begin failures++; $display("FAIL irq_set_wins got=%b exp=0", int_n); end
    clk1();
    iorq_n = 1'b0; m1_n = 1'b0; clk1();
    iorq_n = 1'b1; m1_n = 1'b1;
    checks++; if (int_n !== 1'b1) begin failures++; $display("FAIL irq_ack2 got=%b exp=1", int_n); end
    LVBL = 1'b1; clk1();
  endtask

  task automatic run_frame(output int pulses);
    pulses = 0;
    LVBL = 1'b1;
    repeat (3) begin clk1(); if (wdog_rst) pulses++; end
    LVBL = 1'b0;
    repeat (3) begin clk1(); if (wdog_rst) pulses++; end
    LVBL = 1'b1;
  endtask

  task automatic check_frame(input string name);
    int p;
    run_frame(p);
    checks++;
    if (p !== exp_q[0]) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, p, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_wdog();
    LVBL = 1'b1;
    bank_write(8'h05);
    for (int f = 0; f < 4; f++) begin
      exp_q.push_back((f == 3) ? 1 : 0);
      check_frame("wdog_free_run");
    end
    for (int w = 0; w < 2; w++) begin
      bank_write(8'h05);
      for (int f = 0; f < 3; f++) begin
        exp_q.push_back(0);
        check_frame("wdog_fed");
      end
    end
    exp_q.push_back(1);
    check_frame("wdog_after_feed");
  endtask

  task automatic test_reset_midburst();
    bank_write(8'h07);
    LVBL = 1'b1; clk1(); clk1();
    LVBL = 1'b0; clk1(); clk1();
    A = 16'hB000; mreq_n = 1'b0;
    wait_tick(); wait_tick();
    checks++; if (bank !== 2'd3) begin failures++; $display("FAIL pre_rst_bank got=%h exp=3", bank); end
    checks++; if (int_n !== 1'b0) begin failures++; $display("FAIL pre_rst_int_n got=%b exp=0", int_n); end
    @(posedge clk); #3;
    comb_rstn = 1'b0; #1;
    checks++; if ({rom_cs, fm_cs, cab_cs, ram_cs} !== 4'b0000) begin failures++; $display("FAIL mid_rst_cs got=%b exp=0000", {rom_cs, fm_cs, cab_cs, ram_cs}); end
    checks++; if ({bank, mcu_rst} !== 3'b000) begin failures++; $display("FAIL mid_rst_bank got=%b exp=000", {bank, mcu_rst}); end
    checks++; if (din !== 8'h00) begin failures++; $display("FAIL mid_rst_din got=%h exp=00", din); end
    checks++; if (int_n !== 1'b1) begin failures++; $display("FAIL mid_rst_int_n got=%b exp=1", int_n); end
    checks++; if ({dev_busy, wdog_rst} !== 2'b00) begin failures++; $display("FAIL mid_rst_busy_wdog got=%b exp=00", {dev_busy, wdog_rst}); end
    idle();
    @(negedge clk);
    comb_rstn = 1'b1;
    repeat (3) clk1();
    checks++; if (int_n !== 1'b1) begin failures++; $display("FAIL no_false_edge got=%b exp=1", int_n); end
    LVBL = 1'b1; clk1(); clk1();
  endtask

  initial begin
    comb_rstn = 1'b0; LVBL = 1'b1; cpu_dout = 8'h00;
    rom_data = 8'h11; ram_dout = 8'h22; fm_dout = 8'h33; cab_dout = 8'h44;
    idle();
    #23;
    comb_rstn = 1'b1;
    test_reset();
    clk1();
    test_bank();
    test_din_mux();
    test_fm_wait();
    test_irq();
    test_wdog();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtkiwi_sndctl.md
# jtkiwi_sndctl

Parametrised sound-CPU control block for the Kiwi-family sound subsystem. It sits between the sound Z80 (jtframe_z80_devwait) and its peripherals. It decodes the memory map into registered chip selects, holds the ROM bank and MCU-reset register, builds the CPU data-in mux, generates the VBLANK interrupt with a selectable acknowledge mode, stretches FM wait states, and adds a frame-based watchdog.

## Interface
Parameters:
- BANKW, 2: bank register width; ROM address width is 14+BANKW; must be ≥1.
- FMWAIT, 1: cen6 ticks of wait inserted per new FM access (1..15).
- WDOG_EN, 1: 1 enables the watchdog; 0 holds wdog_rst low.
- WDOG_FRAMES, 8: VBLANK edges without a bank write before the watchdog fires (2..255).
- IRQ_M1, 0: 0 = acknowledge on !iorq_n; 1 = acknowledge on !iorq_n && !m1_n.

Ports:
- clk  in  1  system clock
- comb_rstn  in  1  asynchronous, active-low reset
- cen6  in  1  CPU clock enable
- LVBL  in  1  active-low vertical blank
- A  in  16  CPU address
- mreq_n, rfsh_n, iorq_n, m1_n, wr_n  in  1 each  Z80 bus strobes
- cpu_dout  in  8  CPU write data
- rom_data, ram_dout, fm_dout, cab_dout  in  8 each  device read data
- mshramen  in  1  main CPU holds shared RAM
- rom_addr  out  14+BANKW  ROM byte address
- rom_cs, fm_cs, cab_cs, ram_cs  out  1 each  registered chip selects
- bank  out  BANKW  current ROM bank
- mcu_rst  out  1  MCU reset bit
- din  out  8  registered CPU read data
- int_n  out  1  Z80 INT
- dev_busy  out  1  wait request to CPU wrapper
- wdog_rst  out  1  one-clk watchdog reset request

## Operation
- mem_acc = !mreq_n && rfsh_n.
- Decode on A[15:12]: <0xA → rom_cs; 0xA → bank write region; 0xB → fm_cs; 0xC → cab_cs; 0xD or 0xE → ram_cs; 0xF → no select, din = 0x00.
- rom_addr is combinational: if A[15] = 1, {1'b1, bank, A[12:0]}; otherwise zero-extended A[14:0].
- Bank register: written only when the bank region is selected and !wr_n. bank ← cpu_dout[BANKW-1:0]; mcu_rst ← cpu_dout[BANKW]. Reads of the bank region do not change it.
- din is a registered priority mux: rom_cs, ram_cs, fm_cs, cab_cs, else 0x00.
- IRQ flip-flop: set on the falling edge of LVBL, detected by comparing against a registered copy. Cleared by acknowledge per IRQ_M1. If set and clear occur in the same cycle, set wins. int_n is the inverted flop output.
- FM wait: on the first cen6 tick where fm_cs is high and was low on the previous tick, load the counter with FMWAIT. Decrement it on each cen6 tick. fm_busy = (counter ≠ 0).
- dev_busy = (mshramen && ram_cs) || fm_busy.
- Watchdog: a frame counter increments on each LVBL falling edge and clears on every bank write. A bank write in the same cycle as an edge clears the counter and wins. When an edge arrives with the counter at WDOG_FRAMES-1, wdog_rst pulses for 1 clk and the counter returns to 0.

## Timing
- Reset values: rom_cs, fm_cs, cab_cs, ram_cs = 0; bank = 0; mcu_rst = 0; din = 0x00; int_n = 1; dev_busy = 0; wdog_rst = 0; all counters = 0.
- Chip selects have 1 clk latency from A/mreq_n. din has 1 further clk of latency.
- The bank takes effect 1 clk after the bank write is decoded; rom_addr reflects it immediately afterwards.
- int_n falls 1 clk after the clk where the LVBL fall is seen, and rises 1 clk after acknowledge.
- fm_busy asserts on the cen6 tick after fm_cs rises and lasts exactly FMWAIT cen6 ticks. A continuously held fm_cs does not retrigger.
- Reset asserted mid-operation clears everything asynchronously. After release, the first LVBL edge is detected only after one LVBL sample has been taken.

## Structure
- Shared package jtkiwi_snd_pkg: region code constants (REG_BANK = 4'hA, REG_FM = 4'hB, REG_CAB = 4'hC, REG_RAM0 = 4'hD, REG_RAM1 = 4'hE) and the ROM limit 4'hA.
- One sub-module, jtkiwi_sndctl_wdog: the LVBL edge detector plus frame counter. It exports the edge pulse to the IRQ logic and outputs wdog_rst.

## Test plan
- Bank write: A = 0xA000, cpu_dout = 0x05, !wr_n → bank = 1, mcu_rst = 1; then A = 0x8123 gives rom_addr = 0xA123 (BANKW = 2).
- Bank read at 0xA000 with wr_n = 1 → bank unchanged. A = 0x4321 → rom_addr = 0x4321, rom_cs = 1 after 1 clk.
- FMWAIT = 3, fm_cs held for 10 ticks → dev_busy high for exactly 3 cen6 ticks, then low. mshramen = 1 with ram_cs = 1 → dev_busy = 1.
- IRQ_M1 = 1: an iorq_n pulse with m1_n = 1 leaves int_n = 0; iorq_n and m1_n both low → int_n = 1 next clk. An LVBL fall in the same clk as acknowledge leaves int_n = 0.
- WDOG_FRAMES = 4 with no bank writes → wdog_rst pulses one clk on the 4th LVBL fall. A bank write every 3 frames gives no pulse.
- Assert comb_rstn low mid-burst → all outputs at reset values in the same cycle.
